// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronises sclk/mosi/ss into the clk domain and exchanges
// DATA_W-bit words MSB first through valid/ready rx and tx ports.
// state  | meaning
// IDLE   | ss high, miso parked at 0, waiting for ss low
// ACTIVE | frame in progress, shifting on detected sclk edges
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_d;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_shift_in;
  logic [DATA_W-1:0]      r_shift_out;
  logic [DATA_W-1:0]      r_tx_hold;
  logic                   r_tx_full;
  logic                   r_tx_underrun;
  logic                   r_word_pend;
  logic                   r_word_vld;
  logic [DATA_W-1:0]      r_word;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_overrun;

  logic w_sclk_s, w_mosi_s, w_ss_s, w_rise, w_fall, w_load, w_tx_wr;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;
  assign w_fall   = ~w_sclk_s & r_sclk_d;

  // LOAD happens on frame entry and on the falling edge that closes a word.
  assign w_load  = (r_state == IDLE && !w_ss_s) ||
                   (r_state == ACTIVE && !w_ss_s && w_fall && r_bit_cnt == CNT_FULL);
  assign w_tx_wr = tx_valid & ~r_tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_sclk_d    <= w_sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_shift_in    <= '0;
      r_shift_out   <= '0;
      r_tx_hold     <= '0;
      r_tx_full     <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_word_pend   <= 1'b0;
    end else begin
      r_word_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_ss_s) begin
            r_state   <= ACTIVE;
            r_bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (w_ss_s) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
          end else if (w_rise && r_bit_cnt != CNT_FULL) begin
            r_shift_in <= {r_shift_in[DATA_W-2:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == CNT_LAST)
              r_word_pend <= 1'b1;
          end else if (w_fall) begin
            if (r_bit_cnt == CNT_FULL)
              r_bit_cnt <= '0;
            else if (r_bit_cnt != '0)
              r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
          end
        end
        default: r_state <= IDLE;
      endcase

      // Load sees the holding register as it was before this cycle's write.
      if (w_load) begin
        r_shift_out <= r_tx_full ? r_tx_hold : '0;
        if (!r_tx_full)
          r_tx_underrun <= 1'b1;
      end
      if (w_tx_wr) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_load) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_vld   <= 1'b0;
      r_word       <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_word_vld <= r_word_pend;
      if (r_word_pend)
        r_word <= r_shift_in;
      if (r_word_vld) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign miso        = (r_state == ACTIVE) & r_shift_out[DATA_W-1];
  assign busy        = (r_state == ACTIVE);
  assign tx_ready    = ~r_tx_full;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI mode-0 master plus a word-level
// reference model (sent words in, tx words out, sticky flags).
module tb_spi_slave;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss = 1'b1;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] got_q[$];

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // every accepted word is recorded once, on the handshake cycle
  always @(negedge clk)
    if (!rst && rx_valid && rx_ready) got_q.push_back(rx_data);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    check_eq("tx_ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    mosi = mo;
    tick(HALF);
    sclk = 1'b1;
    mi = miso;
    tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic b;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mo[7-i], b);
      mi = {mi[6:0], b};
    end
  endtask

  task automatic frame_open();
    ss = 1'b0;
    tick(8);
  endtask

  task automatic frame_close();
    tick(HALF);
    ss = 1'b1;
    tick(8);
  endtask

  initial begin
    logic [7:0] mi, m0, m1, w;
    logic       b;
    int         lat;
    logic [7:0] sent[3];
    logic [7:0] txw[3];
    logic       wr[3];
    int         nw;

    #1 rst = 1'b1;
    tick(3);
    check_eq("rst_miso", miso, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {rx_overrun, tx_underrun}, 0);
    rst = 1'b0;
    tick(2);

    // single word with latency measurement on the last rising edge
    got_q.delete();
    tx_write(8'hA5);
    frame_open();
    check_eq("busy_active", busy, 1);
    spi_bits(8'h3C, 7, mi);
    mosi = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    b = miso;
    mi = {mi[6:0], b};
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (rx_valid) begin
        lat = k - 1;
        break;
      end
    end
    check_eq("rx_latency", lat, 4);
    check_eq("rx_data_3c", rx_data, 8'h3C);
    check_eq("no_underrun", tx_underrun, 0);
    tick(HALF - 1);
    sclk = 1'b0;
    frame_close();
    check_eq("miso_a5", mi, 8'hA5);

    // two back-to-back words in one frame
    got_q.delete();
    tx_write(8'h11);
    frame_open();
    tx_write(8'h22);
    spi_bits(8'h81, 8, m0);
    tick(4);
    spi_bits(8'h7E, 8, m1);
    frame_close();
    check_eq("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("b2b_rx0", got_q[0], 8'h81);
      check_eq("b2b_rx1", got_q[1], 8'h7E);
    end
    check_eq("b2b_miso0", m0, 8'h11);
    check_eq("b2b_miso1", m1, 8'h22);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    frame_open();
    spi_bits(8'h01, 8, m0);
    tick(4);
    spi_bits(8'h02, 8, m1);
    frame_close();
    check_eq("ovr_valid", rx_valid, 1);
    check_eq("ovr_data", rx_data, 8'h01);
    check_eq("ovr_flag", rx_overrun, 1);
    rx_ready = 1'b1;
    tick(1);
    check_eq("ovr_drain", rx_valid, 0);
    tick(2);

    // underrun: nothing written
    pulse_rst();
    check_eq("ovr_cleared", rx_overrun, 0);
    check_eq("udr_clear", tx_underrun, 0);
    got_q.delete();
    w = 8'($urandom);
    frame_open();
    spi_bits(w, 8, mi);
    frame_close();
    check_eq("udr_miso", mi, 0);
    check_eq("udr_flag", tx_underrun, 1);
    check_eq("udr_rx", (got_q.size() == 1) ? got_q[0] : 8'hxx, w);

    // abort after 5 bits, then a fresh frame
    got_q.delete();
    frame_open();
    spi_bits(8'hFF, 5, mi);
    frame_close();
    check_eq("abort_valid", rx_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_count", got_q.size(), 0);
    frame_open();
    spi_bits(8'hC3, 8, mi);
    frame_close();
    check_eq("fresh_count", got_q.size(), 1);
    check_eq("fresh_data", rx_data, 8'hC3);

    // async reset mid-word
    tx_write(8'hFF);
    frame_open();
    tx_write(8'h80);
    check_eq("pre_rst_full", tx_ready, 0);
    spi_bits(8'h00, 3, mi);
    rst = 1'b1;
    #2;
    check_eq("arst_miso", miso, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_rx_valid", rx_valid, 0);
    check_eq("arst_rx_data", rx_data, 0);
    check_eq("arst_tx_ready", tx_ready, 1);
    check_eq("arst_flags", {rx_overrun, tx_underrun}, 0);
    tick(2);
    rst = 1'b0;
    tick(8);
    got_q.delete();
    spi_bits(8'h5A, 8, mi);
    frame_close();
    check_eq("post_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) check_eq("post_rst_rx", got_q[0], 8'h5A);

    // randomized frames against the word-level model
    for (int f = 0; f < 6; f++) begin
      nw = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) begin
        sent[k] = 8'($urandom);
        txw[k]  = 8'($urandom);
        wr[k]   = ($urandom_range(0, 3) != 0);
      end
      got_q.delete();
      if (wr[0]) tx_write(txw[0]);
      frame_open();
      for (int k = 0; k < nw; k++) begin
        if (k > 0) tick(4);
        if (k + 1 < nw && wr[k+1]) tx_write(txw[k+1]);
        spi_bits(sent[k], 8, mi);
        check_eq("rnd_miso", mi, wr[k] ? txw[k] : 8'h00);
      end
      frame_close();
      check_eq("rnd_count", got_q.size(), nw);
      for (int k = 0; k < nw; k++)
        if (k < got_q.size()) check_eq("rnd_rx", got_q[k], sent[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: DATA_W, default 8, frame width in bits, MSB first.
REQ-002 Parameter: SYNC_STAGES, default 2, synchroniser depth on sclk, mosi and ss (minimum 2).
REQ-003 Port: clk  input  1  system clock; all state on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: sclk  input  1  SPI clock from master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-006 Port: mosi  input  1  serial data from master.
REQ-007 Port: ss  input  1  slave select, active-low.
REQ-008 Port: miso  output  1  serial data to master, always driven (no tristate).
REQ-009 Port: rx_data  output  DATA_W  last received word.
REQ-010 Port: rx_valid  output  1  rx_data holds an unconsumed word.
REQ-011 Port: rx_ready  input  1  consumer accepts rx_data when rx_valid&&rx_ready.
REQ-012 Port: tx_data  input  DATA_W  word to transmit next.
REQ-013 Port: tx_valid  input  1  tx_data offered.
REQ-014 Port: tx_ready  output  1  tx holding register empty; write on tx_valid&&tx_ready.
REQ-015 Port: rx_overrun  output  1  sticky: a word was received while rx_valid was high.
REQ-016 Port: tx_underrun  output  1  sticky: a word was loaded for transmission while the tx holding register was empty.
REQ-017 Port: busy  output  1  high in ACTIVE state.

Function
REQ-018 sclk, mosi and ss SHALL each pass through SYNC_STAGES flops; sclk edges SHALL be detected by one further register compare.
REQ-019 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-020 In IDLE, synchronised ss==0 (level, not edge) SHALL trigger a LOAD, clear bit_cnt to 0 and enter ACTIVE next cycle.
REQ-021 LOAD SHALL copy the tx holding register into the shift-out register and mark the holding register empty; if it is empty, the load SHALL use all-zeros and set tx_underrun.
REQ-022 miso SHALL equal shift-out MSB in ACTIVE and 0 in IDLE.
REQ-023 On each detected sclk rising edge in ACTIVE: shift-in <= {shift-in[DATA_W-2:0], mosi_sync}; bit_cnt += 1.
REQ-024 On each detected sclk falling edge in ACTIVE with bit_cnt not 0 and not DATA_W: shift-out shifts left by one, zero fill.
REQ-025 On the rising edge that makes bit_cnt==DATA_W: the next cycle SHALL present the complete word. If rx_valid is low, or rx_ready is high in that same cycle, rx_data is updated and rx_valid is set. Otherwise the word is dropped, rx_data is kept and rx_overrun is set.
REQ-026 On the first falling edge with bit_cnt==DATA_W: a LOAD SHALL occur and bit_cnt SHALL be cleared to 0, supporting back-to-back words within one ss-low frame.
REQ-027 Latency: rx_valid SHALL rise exactly SYNC_STAGES+2 clk cycles after the clk edge that first samples sclk high for the last bit (4 at default).
REQ-028 rx_valid SHALL clear the cycle after an rx_valid&&rx_ready handshake unless a new word is loaded in that same cycle.
REQ-029 tx_ready SHALL equal NOT holding-register-full. A LOAD and a tx write in the same cycle SHALL use the register state from before that cycle: if the register was empty, zeros are sent, underrun is flagged, and the write is stored.
REQ-030 Synchronised ss rising in ACTIVE (mid-word or not) SHALL abort: discard partial shift-in, no rx_valid, clear bit_cnt, return to IDLE. A loaded tx word is lost.
REQ-031 Input timing: the sclk high and low phases are each at least SYNC_STAGES+2 clk periods; ss must not toggle within 2 clk periods of an sclk edge.
REQ-032 rx_overrun and tx_underrun SHALL clear only on rst.

Reset
REQ-033 On rst high, immediately and asynchronously: state IDLE; miso, rx_valid, rx_overrun, tx_underrun and busy 0; rx_data 0; bit_cnt 0; tx_ready 1; all synchroniser flops 1 for ss and 0 for sclk/mosi.
REQ-034 rst asserted mid-word SHALL discard all in-flight data. After release, receive resumes at the next LOAD.

Verification
REQ-035 Preload tx 0xA5, ss low, master sends 0x3C -> rx_data=0x3C, rx_valid 4 cycles after the 8th rising edge; master captures 0xA5 on miso.
REQ-036 Hold ss low for a 2-word frame with tx writes 0x11, 0x22; master sends 0x81, 0x7E -> rx words 0x81 then 0x7E in order; master receives 0x11, 0x22.
REQ-037 rx_ready held low for 2 words (0x01, 0x02) -> rx_data stays 0x01, rx_overrun=1; then rx_ready=1 -> rx_valid drops.
REQ-038 No tx write, ss low -> miso all zeros and tx_underrun=1.
REQ-039 Raise ss after 5 bits -> no rx_valid, busy=0. A fresh frame carrying 0xC3 is received correctly.
REQ-040 Assert rst after 3 bits -> all outputs reach reset values without a clk edge. With ss still low after release, the next full word 0x5A is received.
